// File: rtl/xor_stream_pkg.sv
// Shared types and helpers for the streaming XOR checksum block.
//   state_e  : packet-position state (IDLE = nothing accepted yet, ACCUM = mid-packet)
//   sat_max  : saturation value of an len_w-bit word counter (2**len_w - 1)
package xor_stream_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_e;

    function automatic int unsigned sat_max(input int unsigned len_w);
        return (32'd1 << len_w) - 32'd1;
    endfunction

endpackage

// File: rtl/mux2.sv
// Basic 2:1 mux cell, the only primitive the XOR logic is built from.
//   a   : selected when sel = 0
//   b   : selected when sel = 1
//   sel : select
//   y   : output
module mux2 (
    input  logic a,
    input  logic b,
    input  logic sel,
    output logic y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/xor_using_mux.sv
// 1-bit XOR gate made of two mux2 cells.
//   a, b : operands
//   y    : a ^ b
// The first mux acts as an inverter on b (constants on its data inputs);
// the second picks b or ~b depending on a.
module xor_using_mux (
    input  logic a,
    input  logic b,
    output logic y
);

    logic b_n;

    mux2 u_inv (.a(1'b1), .b(1'b0), .sel(b), .y(b_n));
    mux2 u_sel (.a(b),    .b(b_n),  .sel(a), .y(y));

endmodule

// File: rtl/xor_vec_using_mux.sv
// Bitwise WIDTH-bit XOR, one mux-built XOR gate per bit.
//   a, b : operands
//   y    : a ^ b
module xor_vec_using_mux #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        xor_using_mux u_xor (.a(a[i]), .b(b[i]), .y(y[i]));
    end

endmodule

// File: rtl/xor_stream_checksum.sv
// Streaming XOR checksum: accumulates the XOR of every word in a packet
// (packet end marked by in_last) and emits one result per packet.
//   clk, rst_n           : clock, async active-low reset
//   in_valid/in_ready    : input handshake
//   in_data, in_last     : input word and end-of-packet marker
//   out_valid/out_ready  : result handshake
//   out_sum              : XOR of all words in the packet
//   out_len              : word count, saturating at 2**LEN_W-1
//   out_parity           : XOR-reduction of out_sum
//   out_ovf              : packet was longer than 2**LEN_W-1 words
module xor_stream_checksum
    import xor_stream_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic [LEN_W-1:0] out_len,
    output logic             out_parity,
    output logic             out_ovf
);

    localparam logic [LEN_W-1:0] CNT_MAX   = LEN_W'(sat_max(LEN_W));
    localparam logic [LEN_W:0]   CNT_MAX_W = {1'b0, CNT_MAX};

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_sum_q, out_sum_d;
    logic [LEN_W-1:0] out_len_q, out_len_d;
    logic             out_parity_q, out_parity_d;
    logic             out_ovf_q, out_ovf_d;

    logic             in_fire, out_fire;
    logic [WIDTH-1:0] sum_nxt;
    logic             par_nxt;
    logic [LEN_W:0]   cnt_inc;
    logic [LEN_W-1:0] cnt_sat;
    logic             at_max;

    // A pending result blocks input unless it is being taken this cycle,
    // so the result slot is never overwritten before it is consumed.
    assign in_ready = !out_valid_q || out_ready;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid_q && out_ready;

    xor_vec_using_mux #(.WIDTH(WIDTH)) u_xor_vec (
        .a (acc_q),
        .b (in_data),
        .y (sum_nxt)
    );

    // Parity as a linear chain of mux XOR gates; each stage is its own
    // net so the chain never feeds back into a single vector.
    for (genvar i = 0; i < WIDTH; i++) begin : g_par
        logic p;
        if (i == 0) begin : g_first
            assign p = sum_nxt[0];
        end else begin : g_stage
            xor_using_mux u_xor (.a(g_par[i-1].p), .b(sum_nxt[i]), .y(p));
        end
    end
    assign par_nxt = g_par[WIDTH-1].p;

    // One extra adder bit keeps the increment from wrapping before the clamp.
    assign cnt_inc = {1'b0, cnt_q} + {{LEN_W{1'b0}}, 1'b1};
    assign at_max  = (cnt_q == CNT_MAX);
    assign cnt_sat = (cnt_inc > CNT_MAX_W) ? CNT_MAX : cnt_inc[LEN_W-1:0];

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        ovf_d        = ovf_q;
        out_valid_d  = out_valid_q;
        out_sum_d    = out_sum_q;
        out_len_d    = out_len_q;
        out_parity_d = out_parity_q;
        out_ovf_d    = out_ovf_q;

        if (out_fire) begin
            out_valid_d = 1'b0;
        end

        if (in_fire) begin
            if (in_last) begin
                // A new result may load in the same cycle the old one leaves.
                out_valid_d  = 1'b1;
                out_sum_d    = sum_nxt;
                out_len_d    = cnt_sat;
                out_parity_d = par_nxt;
                out_ovf_d    = ovf_q | at_max;
                acc_d        = '0;
                cnt_d        = '0;
                ovf_d        = 1'b0;
                state_d      = IDLE;
            end else begin
                acc_d   = sum_nxt;
                cnt_d   = cnt_sat;
                ovf_d   = ovf_q | at_max;
                state_d = ACCUM;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
            out_valid_q  <= 1'b0;
            out_sum_q    <= '0;
            out_len_q    <= '0;
            out_parity_q <= 1'b0;
            out_ovf_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            ovf_q        <= ovf_d;
            out_valid_q  <= out_valid_d;
            out_sum_q    <= out_sum_d;
            out_len_q    <= out_len_d;
            out_parity_q <= out_parity_d;
            out_ovf_q    <= out_ovf_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_sum    = out_sum_q;
    assign out_len    = out_len_q;
    assign out_parity = out_parity_q;
    assign out_ovf    = out_ovf_q;

endmodule

// File: tb/tb_xor_stream_checksum.sv
module tb_xor_stream_checksum;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic       in_last = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_sum;
    logic [3:0] out_len;
    logic       out_parity;
    logic       out_ovf;

    int checks = 0;
    int errors = 0;

    xor_stream_checksum #(.WIDTH(8), .LEN_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_len    (out_len),
        .out_parity (out_parity),
        .out_ovf    (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [7:0] s,
                             input logic [3:0] l, input logic p, input logic o);
        check({tag, ".valid"},  {31'b0, out_valid},  {31'b0, v});
        check({tag, ".sum"},    {24'b0, out_sum},    {24'b0, s});
        check({tag, ".len"},    {28'b0, out_len},    {28'b0, l});
        check({tag, ".parity"}, {31'b0, out_parity}, {31'b0, p});
        check({tag, ".ovf"},    {31'b0, out_ovf},    {31'b0, o});
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        // Reset state
        #2;
        check_out("reset", 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("reset.in_ready", {31'b0, in_ready}, 32'd1);

        // Single-word packet
        out_ready = 1'b1;
        send(8'hA5, 1'b1);
        check_out("single", 1'b1, 8'hA5, 4'd1, 1'b0, 1'b0);
        step();
        check("single.drain", {31'b0, out_valid}, 32'd0);

        // Three-word packet
        send(8'h0F, 1'b0);
        check("three.w1", {31'b0, out_valid}, 32'd0);
        send(8'hF0, 1'b0);
        check("three.w2", {31'b0, out_valid}, 32'd0);
        send(8'h01, 1'b1);
        check_out("three", 1'b1, 8'hFE, 4'd3, 1'b1, 1'b0);
        step();

        // Backpressure: result 0x3C held while 0x77 waits
        out_ready = 1'b0;
        send(8'h3C, 1'b1);
        in_valid = 1'b1;
        in_data  = 8'h77;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp.in_ready", {31'b0, in_ready}, 32'd0);
            check_out("bp.hold", 1'b1, 8'h3C, 4'd1, 1'b0, 1'b0);
            step();
        end
        out_ready = 1'b1;
        #1;
        check("bp.release_ready", {31'b0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_out("bp.next", 1'b1, 8'h77, 4'd1, 1'b0, 1'b0);
        step();
        check("bp.drain", {31'b0, out_valid}, 32'd0);

        // Back-to-back: pending 0x3C taken while 0x11 is accepted
        out_ready = 1'b0;
        send(8'h3C, 1'b1);
        check_out("b2b.pend", 1'b1, 8'h3C, 4'd1, 1'b0, 1'b0);
        out_ready = 1'b1;
        send(8'h11, 1'b1);
        check_out("b2b.next", 1'b1, 8'h11, 4'd1, 1'b0, 1'b0);
        step();

        // Length boundaries: 15 words (max, no overflow), 16, 17
        for (int i = 0; i < 14; i++) send(8'h01, 1'b0);
        send(8'h01, 1'b1);
        check_out("len15", 1'b1, 8'h01, 4'd15, 1'b1, 1'b0);
        for (int i = 0; i < 15; i++) send(8'h01, 1'b0);
        send(8'h01, 1'b1);
        check_out("len16", 1'b1, 8'h00, 4'd15, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) send(8'h01, 1'b0);
        send(8'h01, 1'b1);
        check_out("len17", 1'b1, 8'h01, 4'd15, 1'b1, 1'b1);
        step();
        // Overflow flag must not leak into the next packet
        send(8'h07, 1'b1);
        check_out("post_ovf", 1'b1, 8'h07, 4'd1, 1'b1, 1'b0);
        step();

        // Reset mid-packet: partial 0xAA, 0x0F discarded
        send(8'hAA, 1'b0);
        send(8'h0F, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("rst_mid", 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        send(8'h55, 1'b1);
        check_out("rst_mid.after", 1'b1, 8'h55, 4'd1, 1'b0, 1'b0);

        // Reset with result pending
        out_ready = 1'b0;
        step();
        check_out("rst_pend.before", 1'b1, 8'h55, 4'd1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("rst_pend", 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        send(8'h81, 1'b1);
        check_out("rst_pend.after", 1'b1, 8'h81, 4'd1, 1'b0, 1'b0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
